// File: rtl/instr_fetch_pkg.sv
// Shared sizes and FSM state encodings for the instruction fetch stage.
// The word/memory-size macros are defined once here and folded into package constants.
`ifndef INSTR_FETCH_DEFINES
`define INSTR_FETCH_DEFINES
`define WORD_SIZE 32
`define MEM_SIZE 256
`endif

package instr_fetch_pkg;

  localparam int WORD_W   = `WORD_SIZE;
  localparam int MEM_SIZE = `MEM_SIZE;
  localparam int ADDR_W   = $clog2(MEM_SIZE);
  localparam int OFFS_W   = 16;
  localparam int JTGT_W   = 26;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus: the fetch stage drives the word address and
// receives combinational read data in the same cycle.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/instr_fetch_pc_next_sel.sv
// Next-PC selection: jump beats taken branch, which beats hold, which beats
// sequential increment. Purely combinational.
module pc_next_sel
  import instr_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              hold,
  input  logic              jump,
  input  logic [JTGT_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_base,
  input  logic [OFFS_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc_next,
  output logic              redirect
);

  logic [OFFS_W-1:0] branch_sum;
  logic              unused_hi;

  // Zero-extending the base and keeping the low byte equals base plus the
  // sign-extended offset, modulo the address space.
  assign branch_sum = {{(OFFS_W-ADDR_W){1'b0}}, branch_base} + branch_offset;
  assign unused_hi  = ^{branch_sum[OFFS_W-1:ADDR_W], jump_target[JTGT_W-1:ADDR_W]};

  always_comb begin
    pc_next  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    redirect = 1'b0;
    if (jump) begin
      pc_next  = jump_target[ADDR_W-1:0];
      redirect = 1'b1;
    end else if (branch_taken) begin
      pc_next  = branch_sum[ADDR_W-1:0];
      redirect = 1'b1;
    end else if (hold) begin
      pc_next  = pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// BOOT/RUN/HALTED sequencing FSM.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_BOOT   | one settle cycle after reset; PC held, nothing captured
//   ST_RUN    | fetching; captures mem_rdata into IF/ID each free cycle
//   ST_HALTED | halt seen; PC held, IF/ID invalid until a redirect
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_base,
  input  logic [OFFS_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [JTGT_W-1:0] jump_target,
  instr_fetch_if.master     imem,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus1,
  output logic              ifid_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next;
  logic              redirect;
  logic              hold;
  logic [WORD_W-1:0] instr_d;
  logic [ADDR_W-1:0] pc_plus1_d;
  logic              valid_d;
  logic [CNT_W-1:0]  count_d;

  assign imem.mem_addr = pc_q;
  assign hold          = stall | halt | (state_q != ST_RUN);

  pc_next_sel u_pc_next_sel (
    .pc            (pc_q),
    .hold          (hold),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .pc_next       (pc_next),
    .redirect      (redirect)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
      fetch_count   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr    <= instr_d;
      ifid_pc_plus1 <= pc_plus1_d;
      ifid_valid    <= valid_d;
      fetch_count   <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = ifid_instr;
    pc_plus1_d = ifid_pc_plus1;
    valid_d    = ifid_valid;
    count_d    = fetch_count;
    unique case (state_q)
      ST_BOOT: begin
        valid_d = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        pc_d = pc_next;
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = '0;
        end else if (halt) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
        end else if (!stall && !flush) begin
          instr_d    = imem.mem_rdata;
          pc_plus1_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          valid_d    = 1'b1;
          count_d    = fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!stall) begin
          pc_plus1_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        // A flushed capture never counts and never becomes valid.
        if (flush && !redirect) begin
          valid_d = 1'b0;
          instr_d = '0;
        end
      end
      ST_HALTED: begin
        pc_d    = pc_next;
        valid_d = 1'b0;
        if (redirect) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam logic [7:0] RESET_PC = 8'h00;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, halt, branch_taken, jump;
  logic [7:0]  branch_base;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc_plus1;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];

  int          m_mode;
  logic [7:0]  m_pc;
  logic [7:0]  m_pp1;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [15:0] m_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_fetch_if bus ();
  assign bus.mem_rdata = mem[bus.mem_addr];

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem          (bus),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .fetch_count   (fetch_count)
  );

  task automatic set_idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
    branch_base = 8'h00; branch_offset = 16'h0000; jump_target = 26'h0;
  endtask

  // Advance the model by the fetch rules using the inputs about to be sampled,
  // then let the DUT take the same edge and settle.
  task automatic step();
    int         t;
    logic [7:0] tgt;
    logic       redir;
    redir = jump || branch_taken;
    t = int'(branch_base) + int'($signed(branch_offset));
    t = ((t % 256) + 256) % 256;
    tgt = jump ? jump_target[7:0] : 8'(t);
    if (rst) begin
      m_mode = M_BOOT; m_pc = RESET_PC; m_pp1 = 8'h00;
      m_instr = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (redir) begin
        m_pc = tgt; m_valid = 1'b0; m_instr = 32'h0;
      end else if (halt) begin
        m_mode = M_HALT; m_valid = 1'b0;
        if (flush) m_instr = 32'h0;
      end else if (stall) begin
        if (flush) begin m_valid = 1'b0; m_instr = 32'h0; end
      end else if (flush) begin
        m_pp1 = m_pc + 8'd1; m_pc = m_pc + 8'd1;
        m_valid = 1'b0; m_instr = 32'h0;
      end else begin
        m_instr = mem[m_pc]; m_pp1 = m_pc + 8'd1; m_valid = 1'b1;
        m_cnt = m_cnt + 16'd1; m_pc = m_pc + 8'd1;
      end
    end else begin
      if (redir) begin m_pc = tgt; m_mode = M_RUN; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.mem_addr !== RESET_PC) $display("FAIL reset_addr got %h want %h", bus.mem_addr, RESET_PC); else passed++;
    checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ifid_valid); else passed++;
    checks++; if (ifid_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", ifid_instr); else passed++;
    checks++; if (ifid_pc_plus1 !== 8'h00) $display("FAIL reset_pp1 got %h want 0", ifid_pc_plus1); else passed++;
    checks++; if (fetch_count !== 16'h0) $display("FAIL reset_count got %h want 0", fetch_count); else passed++;
  endtask

  task automatic test_sequential();
    set_idle();
    step();
    checks++; if (ifid_valid !== 1'b0 || bus.mem_addr !== 8'd0) $display("FAIL boot_hold got valid=%b addr=%h want 0/00", ifid_valid, bus.mem_addr); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ifid_instr !== mem[i]) $display("FAIL seq_instr[%0d] got %h want %h", i, ifid_instr, mem[i]); else passed++;
      checks++; if (ifid_pc_plus1 !== 8'(i + 1) || ifid_valid !== 1'b1) $display("FAIL seq_pp1[%0d] got %h/%b want %h/1", i, ifid_pc_plus1, ifid_valid, 8'(i + 1)); else passed++;
    end
    checks++; if (fetch_count !== 16'd3) $display("FAIL seq_count got %0d want 3", fetch_count); else passed++;
    checks++; if (bus.mem_addr !== 8'd3) $display("FAIL seq_addr got %h want 03", bus.mem_addr); else passed++;
  endtask

  task automatic test_branch();
    set_idle(); jump = 1'b1; jump_target = 26'h5;
    step();
    set_idle(); branch_taken = 1'b1; branch_base = 8'd5; branch_offset = 16'hFFFD;
    step();
    checks++; if (bus.mem_addr !== 8'd2) $display("FAIL branch_addr got %h want 02", bus.mem_addr); else passed++;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL branch_kill got %b/%h want 0/0", ifid_valid, ifid_instr); else passed++;
    set_idle();
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== mem[2]) $display("FAIL branch_resume got %b/%h want 1/%h", ifid_valid, ifid_instr, mem[2]); else passed++;
  endtask

  task automatic test_jump_over_stall();
    set_idle(); jump = 1'b1; jump_target = 26'h0000107; stall = 1'b1;
    step();
    checks++; if (bus.mem_addr !== 8'd7) $display("FAIL jump_stall_addr got %h want 07", bus.mem_addr); else passed++;
    checks++; if (ifid_valid !== 1'b0) $display("FAIL jump_stall_valid got %b want 0", ifid_valid); else passed++;
    set_idle();
    step();
    checks++; if (ifid_instr !== mem[7] || ifid_pc_plus1 !== 8'd8) $display("FAIL jump_resume got %h/%h want %h/08", ifid_instr, ifid_pc_plus1, mem[7]); else passed++;
  endtask

  task automatic test_stall();
    logic [15:0] cnt_before;
    set_idle(); jump = 1'b1; jump_target = 26'h3;
    step();
    set_idle();
    step();
    cnt_before = m_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.mem_addr !== 8'd4) $display("FAIL stall_addr[%0d] got %h want 04", i, bus.mem_addr); else passed++;
      checks++; if (ifid_instr !== mem[3] || ifid_pc_plus1 !== 8'd4 || ifid_valid !== 1'b1) $display("FAIL stall_ifid[%0d] got %h/%h/%b want %h/04/1", i, ifid_instr, ifid_pc_plus1, ifid_valid, mem[3]); else passed++;
      checks++; if (fetch_count !== cnt_before) $display("FAIL stall_count[%0d] got %0d want %0d", i, fetch_count, cnt_before); else passed++;
    end
    set_idle();
  endtask

  task automatic test_wrap();
    set_idle(); jump = 1'b1; jump_target = 26'h3FFFFFF;
    step();
    checks++; if (bus.mem_addr !== 8'hFF) $display("FAIL wrap_jump got %h want FF", bus.mem_addr); else passed++;
    set_idle();
    step();
    checks++; if (bus.mem_addr !== 8'h00) $display("FAIL wrap_addr got %h want 00", bus.mem_addr); else passed++;
    checks++; if (ifid_pc_plus1 !== 8'h00 || ifid_instr !== mem[255]) $display("FAIL wrap_ifid got %h/%h want 00/%h", ifid_pc_plus1, ifid_instr, mem[255]); else passed++;
  endtask

  task automatic test_halt();
    set_idle(); jump = 1'b1; jump_target = 26'h5;
    step();
    set_idle();
    step();
    halt = 1'b1;
    step();
    checks++; if (bus.mem_addr !== 8'd6 || ifid_valid !== 1'b0) $display("FAIL halt_enter got %h/%b want 06/0", bus.mem_addr, ifid_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      set_idle();
      stall = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      step();
      checks++; if (bus.mem_addr !== 8'd6 || ifid_valid !== 1'b0) $display("FAIL halt_hold[%0d] got %h/%b want 06/0", i, bus.mem_addr, ifid_valid); else passed++;
    end
    set_idle(); jump = 1'b1; jump_target = 26'h0;
    step();
    checks++; if (bus.mem_addr !== 8'd0) $display("FAIL halt_redirect got %h want 00", bus.mem_addr); else passed++;
    set_idle();
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== mem[0] || bus.mem_addr !== 8'd1) $display("FAIL halt_resume got %b/%h/%h want 1/%h/01", ifid_valid, ifid_instr, bus.mem_addr, mem[0]); else passed++;
  endtask

  task automatic test_reset_override();
    set_idle(); rst = 1'b1; jump = 1'b1; jump_target = 26'h40; halt = 1'b1; flush = 1'b1;
    step();
    checks++; if (bus.mem_addr !== RESET_PC || ifid_valid !== 1'b0 || fetch_count !== 16'h0) $display("FAIL rst_override got %h/%b/%0d want %h/0/0", bus.mem_addr, ifid_valid, fetch_count, RESET_PC); else passed++;
    set_idle(); jump = 1'b1; jump_target = 26'h40;
    step();
    checks++; if (bus.mem_addr !== RESET_PC || ifid_valid !== 1'b0) $display("FAIL rst_boot got %h/%b want %h/0", bus.mem_addr, ifid_valid, RESET_PC); else passed++;
    set_idle();
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== mem[RESET_PC]) $display("FAIL rst_first got %b/%h want 1/%h", ifid_valid, ifid_instr, mem[RESET_PC]); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 63) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      halt          = ($urandom_range(0, 15) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_base   = 8'($urandom());
      branch_offset = 16'($urandom());
      jump_target   = 26'($urandom());
      step();
      checks++; if (bus.mem_addr !== m_pc) $display("FAIL rnd_addr[%0d] got %h want %h", n, bus.mem_addr, m_pc); else passed++;
      checks++; if (ifid_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b want %b", n, ifid_valid, m_valid); else passed++;
      checks++; if (ifid_instr !== m_instr) $display("FAIL rnd_instr[%0d] got %h want %h", n, ifid_instr, m_instr); else passed++;
      checks++; if (fetch_count !== m_cnt) $display("FAIL rnd_count[%0d] got %0d want %0d", n, fetch_count, m_cnt); else passed++;
      if (m_valid) begin
        checks++; if (ifid_pc_plus1 !== m_pp1) $display("FAIL rnd_pp1[%0d] got %h want %h", n, ifid_pc_plus1, m_pp1); else passed++;
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    m_mode = M_BOOT; m_pc = RESET_PC; m_pp1 = 8'h0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    for (int i = 0; i < 4; i++) mem[i] = ($urandom() & 32'hFFFF_FFF0) | 32'(i);
    test_reset();
    test_sequential();
    test_branch();
    test_jump_over_stall();
    test_stall();
    test_wrap();
    test_halt();
    test_reset_override();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning the reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  meaning hold PC and IF/ID register.
REQ-005 SHALL have port flush  input  1  meaning kill the IF/ID register contents.
REQ-006 SHALL have port halt  input  1  meaning decode has seen a halt; stop fetching.
REQ-007 SHALL have port branch_taken  input  1  meaning a conditional branch resolved as taken.
REQ-008 SHALL have port branch_base  input  8  meaning PC+1 of the branch instruction.
REQ-009 SHALL have port branch_offset  input  16  meaning the signed word offset.
REQ-010 SHALL have port jump  input  1  meaning an unconditional jump.
REQ-011 SHALL have port jump_target  input  26  meaning the jump target field.
REQ-012 SHALL have port mem_addr  output  8  meaning the word address to instruction memory.
REQ-013 SHALL have port mem_rdata  input  `WORD_SIZE  meaning the combinational read data from memory.
REQ-014 SHALL have port ifid_instr  output  `WORD_SIZE  meaning the captured instruction.
REQ-015 SHALL have port ifid_pc_plus1  output  8  meaning the address of the captured instruction plus 1.
REQ-016 SHALL have port ifid_valid  output  1  meaning ifid_instr holds a real instruction.
REQ-017 SHALL have port fetch_count  output  16  meaning the number of valid instructions captured.

Function
REQ-018 SHALL drive mem_addr combinationally from the PC register; no other logic SHALL feed mem_addr.
REQ-019 SHALL implement an FSM with states BOOT, RUN and HALTED; reset enters BOOT.
REQ-020 In BOOT, SHALL hold PC, keep ifid_valid=0, and go to RUN after exactly 1 cycle.
REQ-021 In RUN, on an edge with no redirect, stall or halt, SHALL set ifid_instr<=mem_rdata, ifid_pc_plus1<=PC+1, ifid_valid<=1, PC<=PC+1, and fetch_count+=1; latency from mem_addr to ifid_instr is 1 cycle.
REQ-022 Next-PC priority in RUN SHALL be: jump > branch_taken > stall > sequential.
REQ-023 Jump target SHALL be jump_target[7:0].
REQ-024 Branch target SHALL be (branch_base + sign-extended branch_offset) mod 256.
REQ-025 On a redirect (jump or branch_taken), SHALL load PC with the target and set ifid_valid<=0 and ifid_instr<=0, discarding the wrong-path word; redirect SHALL override a simultaneous stall.
REQ-026 On stall without redirect, SHALL hold PC, ifid_* and fetch_count unchanged.
REQ-027 On flush, SHALL set ifid_valid<=0 and ifid_instr<=0 regardless of stall; PC update SHALL still follow REQ-022.
REQ-028 On halt in RUN without redirect, SHALL enter HALTED, hold PC, and set ifid_valid<=0.
REQ-029 In HALTED, SHALL hold PC with ifid_valid=0; a redirect SHALL load PC and return the FSM to RUN; stall and flush SHALL have no effect.
REQ-030 PC+1 SHALL wrap 8'hFF->8'h00 silently.
REQ-031 fetch_count SHALL wrap 16'hFFFF->0.

Reset
REQ-032 While rst=1 at an edge, SHALL set PC=RESET_PC, state=BOOT, ifid_instr=0, ifid_pc_plus1=0, ifid_valid=0, fetch_count=0.
REQ-033 rst SHALL override all other inputs, including reset asserted mid-redirect or mid-halt.

Structure
REQ-034 `WORD_SIZE (32), `MEM_SIZE (256), ADDR_W (8) and the FSM state encodings SHALL live in the shared defines header.
REQ-035 Next-PC selection SHALL be one combinational sub-module, pc_next_sel.

Verification
REQ-036 Memory words 0..3 distinct, rst for 2 cycles then released -> BOOT for 1 cycle, then ifid_instr=mem[0] with ifid_pc_plus1=1 and valid=1, then mem[1], then mem[2]; fetch_count=3.
REQ-037 PC=5, branch_taken=1, branch_base=5, branch_offset=16'hFFFD -> next mem_addr=2 and ifid_valid=0 for 1 cycle.
REQ-038 Jump with jump_target=26'h0000107 and stall=1 at the same edge -> mem_addr=7; stall is ignored.
REQ-039 stall held for 3 cycles at PC=4 -> mem_addr=4 and ifid_* stable throughout; fetch_count unchanged.
REQ-040 PC=8'hFF, no events -> next mem_addr=0 and ifid_pc_plus1=0.
REQ-041 halt at PC=6, then idle 4 cycles, then jump_target=0 -> PC stays 6 with valid=0 while halted; the jump resumes fetch at 0.
